// File: rtl/effect_sequencer.sv
// Effect sequencer: hands each upstream sample to the effect bank, returns the
// switch-selected result, and bypasses the dry sample if the bank stalls.
module effect_sequencer #(
    parameter int d_width = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         i_sw,
    input  logic               i_sample_valid,
    input  logic [d_width-1:0] i_sample,
    output logic               o_sample_ack,
    output logic [d_width-1:0] o_fx_data,
    output logic               o_fx_data_ready,
    input  logic               i_fx_read_enable,
    output logic               o_fx_read_done,
    input  logic               i_fx_data_valid,
    input  logic [d_width-1:0] i_fx_data_sw0,
    input  logic [d_width-1:0] i_fx_data_sw1,
    output logic               o_out_valid,
    output logic [d_width-1:0] o_out_data,
    input  logic               i_out_ready,
    output logic               o_busy,
    output logic               o_timeout,
    output logic [7:0]         o_err_count
);

    typedef enum logic [1:0] {IDLE, WAIT_RD, WAIT_VALID, OUTPUT} state_t;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

    state_t             state;
    logic [1:0]         sw_meta;
    logic [1:0]         sw_sync;
    logic [1:0]         sel_reg;
    logic [d_width-1:0] sample_reg;
    logic [15:0]        tmo_count;
    logic               waiting;
    logic               tmo_hit;
    logic [d_width-1:0] fx_result;

    // The switches are asynchronous; only the synchronized copy is ever latched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= i_sw;
            sw_sync <= sw_meta;
        end
    end

    assign waiting = (state == WAIT_RD) || (state == WAIT_VALID);
    assign tmo_hit = waiting && (tmo_count == TMO_LIMIT);

    always_comb begin
        fx_result = i_fx_data_sw1;
        case (sel_reg)
            2'b00:   fx_result = '0;
            2'b01:   fx_result = i_fx_data_sw0;
            default: fx_result = i_fx_data_sw1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            sample_reg      <= '0;
            sel_reg         <= '0;
            tmo_count       <= '0;
            o_sample_ack    <= 1'b0;
            o_fx_data       <= '0;
            o_fx_data_ready <= 1'b0;
            o_fx_read_done  <= 1'b0;
            o_out_valid     <= 1'b0;
            o_out_data      <= '0;
            o_busy          <= 1'b0;
            o_timeout       <= 1'b0;
            o_err_count     <= '0;
        end else begin
            o_sample_ack   <= 1'b0;
            o_fx_read_done <= 1'b0;
            o_timeout      <= 1'b0;
            if (waiting) begin
                tmo_count <= tmo_count + 16'd1;
            end
            // A stalled bank wins over any handshake arriving in the same cycle.
            if (tmo_hit) begin
                o_out_data      <= sample_reg;
                o_out_valid     <= 1'b1;
                o_fx_data_ready <= 1'b0;
                o_timeout       <= 1'b1;
                if (o_err_count != 8'hFF) begin
                    o_err_count <= o_err_count + 8'd1;
                end
                state <= OUTPUT;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_sample_valid) begin
                            sample_reg      <= i_sample;
                            sel_reg         <= sw_sync;
                            o_fx_data       <= i_sample;
                            o_fx_data_ready <= 1'b1;
                            o_sample_ack    <= 1'b1;
                            o_busy          <= 1'b1;
                            tmo_count       <= '0;
                            state           <= WAIT_RD;
                        end
                    end
                    WAIT_RD: begin
                        if (i_fx_read_enable) begin
                            o_fx_data_ready <= 1'b0;
                            o_fx_read_done  <= 1'b1;
                            state           <= WAIT_VALID;
                        end
                    end
                    WAIT_VALID: begin
                        if (i_fx_data_valid) begin
                            o_out_data  <= fx_result;
                            o_out_valid <= 1'b1;
                            state       <= OUTPUT;
                        end
                    end
                    OUTPUT: begin
                        if (i_out_ready) begin
                            o_out_valid <= 1'b0;
                            o_busy      <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_effect_sequencer.sv
// Self-checking bench for effect_sequencer: a scoreboard of expected output
// samples plus per-scenario tasks covering handshakes, timeouts and reset.
module tb_effect_sequencer;

    localparam int DW  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    i_sw = 2'b00;
    logic          i_sample_valid = 1'b0;
    logic [DW-1:0] i_sample = '0;
    logic          o_sample_ack;
    logic [DW-1:0] o_fx_data;
    logic          o_fx_data_ready;
    logic          i_fx_read_enable = 1'b0;
    logic          o_fx_read_done;
    logic          i_fx_data_valid = 1'b0;
    logic [DW-1:0] i_fx_data_sw0 = '0;
    logic [DW-1:0] i_fx_data_sw1 = '0;
    logic          o_out_valid;
    logic [DW-1:0] o_out_data;
    logic          i_out_ready = 1'b0;
    logic          o_busy;
    logic          o_timeout;
    logic [7:0]    o_err_count;

    logic          bank_rd_en = 1'b0;
    logic          bank_valid_en = 1'b0;
    logic          valid_pending = 1'b0;
    logic [DW-1:0] exp_q[$];
    int            tests_run = 0;
    int            tests_failed = 0;

    effect_sequencer #(.d_width(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .i_sw(i_sw),
        .i_sample_valid(i_sample_valid), .i_sample(i_sample), .o_sample_ack(o_sample_ack),
        .o_fx_data(o_fx_data), .o_fx_data_ready(o_fx_data_ready),
        .i_fx_read_enable(i_fx_read_enable), .o_fx_read_done(o_fx_read_done),
        .i_fx_data_valid(i_fx_data_valid), .i_fx_data_sw0(i_fx_data_sw0),
        .i_fx_data_sw1(i_fx_data_sw1), .o_out_valid(o_out_valid), .o_out_data(o_out_data),
        .i_out_ready(i_out_ready), .o_busy(o_busy), .o_timeout(o_timeout),
        .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;

    // Effect bank: reads as soon as data is offered, returns results the cycle after read_done.
    always @(negedge clk) begin
        #1;
        if (reset) valid_pending = 1'b0;
        else if (o_fx_read_done) valid_pending = 1'b1;
        i_fx_read_enable = bank_rd_en && o_fx_data_ready && !reset;
        i_fx_data_valid  = bank_valid_en && valid_pending && !reset;
        if (i_fx_data_valid) valid_pending = 1'b0;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step_cycle();
        logic [DW-1:0] want;
        if (o_out_valid === 1'b1 && i_out_ready === 1'b1 && reset === 1'b0) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL scoreboard_extra: got %h, expected no output", o_out_data);
            end else begin
                want = exp_q.pop_front();
                if (o_out_data !== want) begin
                    tests_failed++;
                    $display("[TB] FAIL scoreboard_data: got %h, expected %h", o_out_data, want);
                end
            end
        end
        @(negedge clk);
        #3;
    endtask

    task automatic send_sample(input logic [DW-1:0] value, input logic [DW-1:0] expect_out,
                               output bit acked);
        acked = 1'b0;
        exp_q.push_back(expect_out);
        i_sample = value;
        i_sample_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step_cycle();
            if (o_sample_ack) begin
                acked = 1'b1;
                break;
            end
        end
        i_sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            step_cycle();
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int activity;
        reset = 1'b1;
        step_cycle();
        step_cycle();
        tests_run++;
        if ({o_busy, o_sample_ack, o_fx_data_ready, o_fx_read_done, o_out_valid, o_timeout} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 000000",
                     {o_busy, o_sample_ack, o_fx_data_ready, o_fx_read_done, o_out_valid, o_timeout});
        end
        tests_run++;
        if (o_fx_data !== 16'h0 || o_out_data !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got fx=%h out=%h, expected 0000", o_fx_data, o_out_data);
        end
        tests_run++;
        if (o_err_count !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_err_count: got %0d, expected 0", o_err_count);
        end
        reset = 1'b0;
        activity = 0;
        for (int c = 0; c < 4; c++) begin
            step_cycle();
            if (o_busy || o_sample_ack || o_fx_data_ready) activity++;
        end
        tests_run++;
        if (activity != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_idle: got %0d active cycles, expected 0", activity);
        end
    endtask

    task automatic test_basic();
        int ack_cnt, rd_cnt, idle_cycle;
        logic [DW-1:0] fx_seen;
        logic rdy_seen;
        ack_cnt = 0; rd_cnt = 0; idle_cycle = -1; fx_seen = '0; rdy_seen = 1'b0;
        i_sw = 2'b01;
        i_fx_data_sw0 = 16'h1234;
        i_fx_data_sw1 = 16'h0FFF;
        bank_rd_en = 1'b1;
        bank_valid_en = 1'b1;
        i_out_ready = 1'b1;
        repeat (3) step_cycle();
        i_sample = 16'h1234;
        i_sample_valid = 1'b1;
        exp_q.push_back(16'h1234);
        for (int c = 0; c < 8; c++) begin
            step_cycle();
            if (o_sample_ack) begin
                ack_cnt++;
                i_sample_valid = 1'b0;
            end
            if (o_fx_read_done) rd_cnt++;
            if (c == 0) begin
                fx_seen = o_fx_data;
                rdy_seen = o_fx_data_ready;
            end
            if (!o_busy && idle_cycle < 0) idle_cycle = c;
        end
        i_sample_valid = 1'b0;
        tests_run++;
        if (fx_seen !== 16'h1234 || rdy_seen !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_fx_offer: got data=%h ready=%b, expected 1234/1", fx_seen, rdy_seen);
        end
        tests_run++;
        if (ack_cnt != 1 || rd_cnt != 1) begin
            tests_failed++;
            $display("[TB] FAIL basic_pulses: got ack=%0d read_done=%0d, expected 1/1", ack_cnt, rd_cnt);
        end
        // Cycle 0 follows the accept edge; the 4th cycle (index 3) must be IDLE.
        tests_run++;
        if (idle_cycle != 3) begin
            tests_failed++;
            $display("[TB] FAIL basic_latency: got idle at cycle %0d, expected 3", idle_cycle);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL basic_output_count: got %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_sw_change();
        bit acked, ok;
        i_sw = 2'b10;
        i_fx_data_sw0 = 16'h1357;
        i_fx_data_sw1 = 16'h3FFC;
        bank_valid_en = 1'b0;
        repeat (3) step_cycle();
        send_sample(16'h7000, 16'h3FFC, acked);
        step_cycle();
        tests_run++;
        if (!acked || o_fx_read_done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL swchg_handshake: got ack=%b read_done=%b, expected 1/1", acked, o_fx_read_done);
        end
        i_sw = 2'b00;
        repeat (3) step_cycle();
        tests_run++;
        if (o_busy !== 1'b1 || o_out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL swchg_waiting: got busy=%b valid=%b, expected 1/0", o_busy, o_out_valid);
        end
        bank_valid_en = 1'b1;
        wait_idle(20, ok);
        tests_run++;
        if (!ok || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL swchg_first: got idle=%b outstanding=%0d, expected 1/0", ok, exp_q.size());
        end
        repeat (2) step_cycle();
        send_sample(16'h2222, 16'h0000, acked);
        wait_idle(20, ok);
        tests_run++;
        if (!acked || !ok || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL swchg_muted: got ack=%b idle=%b outstanding=%0d, expected 1/1/0",
                     acked, ok, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit acked, ok;
        int bad, ack_seen;
        bad = 0; ack_seen = 0;
        i_sw = 2'b01;
        i_fx_data_sw0 = 16'h0ABC;
        i_out_ready = 1'b0;
        repeat (3) step_cycle();
        send_sample(16'h1111, 16'h0ABC, acked);
        step_cycle();
        i_sample = 16'h2222;
        i_sample_valid = 1'b1;
        exp_q.push_back(16'h0BCD);
        step_cycle();
        for (int c = 0; c < 20; c++) begin
            if (o_out_valid !== 1'b1 || o_out_data !== 16'h0ABC || o_busy !== 1'b1) bad++;
            if (o_sample_ack) ack_seen++;
            step_cycle();
        end
        tests_run++;
        if (!acked || bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold: got ack=%b unstable_cycles=%0d, expected 1/0", acked, bad);
        end
        tests_run++;
        if (ack_seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_no_ack: got %0d acks while stalled, expected 0", ack_seen);
        end
        i_out_ready = 1'b1;
        step_cycle();
        tests_run++;
        if (o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_release_idle: got busy=%b valid=%b, expected 0/0", o_busy, o_out_valid);
        end
        step_cycle();
        tests_run++;
        if (o_sample_ack !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_pending_ack: got %b, expected 1", o_sample_ack);
        end
        i_sample_valid = 1'b0;
        i_fx_data_sw0 = 16'h0BCD;
        wait_idle(20, ok);
        tests_run++;
        if (!ok || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_pending_done: got idle=%b outstanding=%0d, expected 1/0", ok, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int tmo_cycle, pulses;
        logic [DW-1:0] data_seen;
        logic valid_seen, rdy_seen;
        logic [7:0] err_seen;
        tmo_cycle = -1; pulses = 0; data_seen = '0; valid_seen = 1'b0; rdy_seen = 1'b1; err_seen = '0;
        bank_rd_en = 1'b0;
        i_out_ready = 1'b1;
        i_sample = 16'h8001;
        i_sample_valid = 1'b1;
        exp_q.push_back(16'h8001);
        for (int c = 0; c < 16; c++) begin
            step_cycle();
            if (o_sample_ack) i_sample_valid = 1'b0;
            if (o_timeout) begin
                pulses++;
                if (tmo_cycle < 0) begin
                    tmo_cycle = c;
                    data_seen = o_out_data;
                    valid_seen = o_out_valid;
                    rdy_seen = o_fx_data_ready;
                    err_seen = o_err_count;
                end
            end
        end
        i_sample_valid = 1'b0;
        // Counter is 0 in the first WAIT_RD cycle and equals TMO in cycle TMO; the pulse follows.
        tests_run++;
        if (tmo_cycle != TMO + 1 || pulses != 1) begin
            tests_failed++;
            $display("[TB] FAIL tmo_timing: got cycle=%0d pulses=%0d, expected %0d/1", tmo_cycle, pulses, TMO + 1);
        end
        tests_run++;
        if (data_seen !== 16'h8001 || valid_seen !== 1'b1 || rdy_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL tmo_bypass: got data=%h valid=%b ready=%b, expected 8001/1/0",
                     data_seen, valid_seen, rdy_seen);
        end
        tests_run++;
        if (err_seen !== 8'd1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL tmo_err_count: got %0d outstanding=%0d, expected 1/0", err_seen, exp_q.size());
        end
        bank_rd_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit acked, ok;
        bank_valid_en = 1'b0;
        i_out_ready = 1'b1;
        send_sample(16'h4444, 16'h0BCD, acked);
        step_cycle();
        step_cycle();
        tests_run++;
        if (!acked || o_busy !== 1'b1 || o_fx_data !== 16'h4444 || o_err_count !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_pre: got ack=%b busy=%b fx=%h err=%0d, expected 1/1/4444/1",
                     acked, o_busy, o_fx_data, o_err_count);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({o_busy, o_sample_ack, o_fx_data_ready, o_fx_read_done, o_out_valid, o_timeout} !== 6'b0 ||
            o_fx_data !== 16'h0 || o_out_data !== 16'h0 || o_err_count !== 8'h0) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_async: got ctrl=%b fx=%h out=%h err=%0d, expected all zero",
                     {o_busy, o_sample_ack, o_fx_data_ready, o_fx_read_done, o_out_valid, o_timeout},
                     o_fx_data, o_out_data, o_err_count);
        end
        exp_q.delete();
        step_cycle();
        step_cycle();
        reset = 1'b0;
        bank_valid_en = 1'b1;
        repeat (3) step_cycle();
        send_sample(16'h5555, 16'h0BCD, acked);
        wait_idle(20, ok);
        tests_run++;
        if (!acked || !ok || exp_q.size() != 0 || o_err_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_recover: got ack=%b idle=%b outstanding=%0d err=%0d, expected 1/1/0/0",
                     acked, ok, exp_q.size(), o_err_count);
        end
    endtask

    task automatic test_saturation();
        bit acked, ok;
        int lost;
        logic [7:0] err_at_200;
        logic [DW-1:0] val;
        lost = 0;
        err_at_200 = '0;
        bank_rd_en = 1'b0;
        i_out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            val = 16'(i * 37 + 1);
            send_sample(val, val, acked);
            wait_idle(30, ok);
            if (!acked || !ok) lost++;
            if (i == 199) err_at_200 = o_err_count;
        end
        tests_run++;
        if (lost != 0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL sat_traffic: got lost=%0d outstanding=%0d, expected 0/0", lost, exp_q.size());
        end
        tests_run++;
        if (err_at_200 !== 8'd200) begin
            tests_failed++;
            $display("[TB] FAIL sat_count_200: got %0d, expected 200", err_at_200);
        end
        tests_run++;
        if (o_err_count !== 8'd255) begin
            tests_failed++;
            $display("[TB] FAIL sat_count_300: got %0d, expected 255", o_err_count);
        end
        bank_rd_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sw_change();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_saturation();
        step_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
